instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- PC register, word-addressed instruction memory and IF/ID pipeline register for the lh/sh/andi/bne datapath.
- Produces the registered instruction word consumed by the immediate generator and the decoder.
- Accepts the branch redirect from the bne resolution logic, including the sign-extended halfword-unit offset.
- Supports stall and flush, and halts on an illegal PC.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in instruction memory (power of two, at least 4).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- stall  in  1  hold PC and IF/ID contents.
- branch_taken  in  1  redirect request from bne resolution.
- branch_pc  in  32  PC of the branch instruction.
- branch_offset  in  32  signed immediate in halfword units.
- imem_we  in  1  instruction memory write enable (program load).
- imem_waddr  in  log2(IMEM_DEPTH)  word address.
- imem_wdata  in  32  word to write.
- pc  out  32  current fetch PC.
- id_pc  out  32  PC of the instruction held in IF/ID.
- id_instruction  out  32  registered instruction word.
- id_valid  out  1  IF/ID holds a real instruction.
- pc_fault  out  1  sticky illegal-PC flag.

Behaviour:
- FSM states: RUN and HALT. Reset enters RUN.
- Reset (rst_n=0 at a posedge) has priority over everything except memory writes:
  - pc=RESET_PC, id_pc=0, id_instruction=NOP_WORD, id_valid=0, pc_fault=0, state=RUN.
  - Memory contents are not cleared.
- Target arithmetic: target = branch_pc + (branch_offset << 1), modulo 2^32, no overflow flag.
- Sequential next PC = pc + 4, modulo 2^32.
- Legal PC: pc[1:0]==0 and pc[31:2] < IMEM_DEPTH.
- RUN, per posedge, in priority order:
  1. branch_taken=1 (overrides stall):
     - pc <= target.
     - IF/ID flushed: id_instruction <= NOP_WORD, id_valid <= 0, id_pc <= 0.
  2. stall=1: pc, id_pc, id_instruction and id_valid all hold.
  3. Otherwise, if the current pc is legal:
     - id_instruction <= imem[pc[k+1:2]], id_pc <= pc, id_valid <= 1, pc <= pc + 4.
  4. Otherwise (current pc illegal):
     - pc_fault <= 1, state <= HALT.
     - id_instruction <= NOP_WORD, id_valid <= 0, pc holds.
- Fetch latency: the word at address pc appears on id_instruction one cycle after pc is presented, when not stalled or flushed.
- A branch to an illegal target is accepted into pc. The fault is raised on the following non-stalled, non-branch cycle (rule 4).
- HALT:
  - pc, id_pc and pc_fault hold; id_valid=0; id_instruction=NOP_WORD.
  - stall and branch_taken are ignored.
  - Only reset exits HALT.
- Memory:
  - Synchronous write on posedge when imem_we=1, in any state, including during reset.
  - Internal read is combinational on pc and is captured into IF/ID.
  - Same-cycle write and fetch of the same address captures the old word (read-before-write).
- pc_fault is asserted only in HALT and clears only on reset.
- Reset asserted mid-stall, mid-branch or in HALT produces the full reset state on that same edge.

Test Plan:
- Load imem[0..3] = 0x00A00093, 0x0010F113, 0x00209463, 0x00011183. Reset, then run 4 cycles.
  -> id_instruction follows those words on cycles 1..4; id_pc = 0,4,8,12; id_valid=1 from cycle 1.
- Run to pc=8, then hold stall=1 for 3 cycles.
  -> pc stays 8; id_instruction stays 0x0010F113 (id_pc=4); fetch resumes at 8 on release.
- With stall=1, assert branch_taken=1, branch_pc=8, branch_offset=32'hFFFF_FFFC.
  -> pc=0 next cycle; id_valid=0; id_instruction=0x00000013; the instruction at 0 appears the following cycle.
- Branch with branch_pc=4, branch_offset=1.
  -> pc=6; next cycle pc_fault=1, state HALT; pc stays 6 despite later branch_taken pulses.
- Run sequentially with IMEM_DEPTH=64 past address 0xFC.
  -> word 63 is fetched; at pc=0x100, pc_fault=1 and id_valid=0.
- In HALT, write imem[0]=0x00000013 with imem_we and rst_n=0 together.
  -> pc=0, pc_fault=0, id_valid=0. After release, id_instruction=0x00000013 with id_pc=0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, word-addressed instruction memory and IF/ID register.
// One-cycle fetch latency; stall holds PC and IF/ID, a taken branch overrides stall and flushes IF/ID.
module instr_fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          stall_i,
    input  logic                          branch_taken_i,
    input  logic [31:0]                   branch_pc_i,
    input  logic [31:0]                   branch_offset_i,
    input  logic                          imem_we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr_i,
    input  logic [31:0]                   imem_wdata_i,
    output logic [31:0]                   pc_o,
    output logic [31:0]                   id_pc_o,
    output logic [31:0]                   id_instruction_o,
    output logic                          id_valid_o,
    output logic                          pc_fault_o
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0] imem_q [IMEM_DEPTH];

    logic [0:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        fault_q,    fault_d;

    logic [31:0] branch_target;
    logic [31:0] pc_seq;
    logic [31:0] fetch_word;
    logic        pc_legal;

    // Offset is in halfword units; wrap-around is intentional.
    assign branch_target = branch_pc_i + (branch_offset_i << 1);
    assign pc_seq        = pc_q + 32'd4;
    assign pc_legal      = (pc_q[1:0] == 2'b00) && (pc_q[31:AW+2] == '0);
    assign fetch_word    = imem_q[pc_q[AW+1:2]];

    // Program load is independent of reset and FSM state; the read above sees the old word.
    always_ff @(posedge clk_i) begin
        if (imem_we_i) begin
            imem_q[imem_waddr_i] <= imem_wdata_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        fault_d    = fault_q;
        case (state_q)
            ST_RUN: begin
                if (branch_taken_i) begin
                    pc_d       = branch_target;
                    id_pc_d    = 32'd0;
                    id_instr_d = NOP_WORD;
                    id_valid_d = 1'b0;
                end else if (!stall_i) begin
                    if (pc_legal) begin
                        pc_d       = pc_seq;
                        id_pc_d    = pc_q;
                        id_instr_d = fetch_word;
                        id_valid_d = 1'b1;
                    end else begin
                        state_d    = ST_HALT;
                        fault_d    = 1'b1;
                        id_instr_d = NOP_WORD;
                        id_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                // HALT: everything already parked (bubble in IF/ID), only reset leaves.
                id_instr_d = NOP_WORD;
                id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_instr_q <= NOP_WORD;
            id_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign pc_o             = pc_q;
    assign id_pc_o          = id_pc_q;
    assign id_instruction_o = id_instr_q;
    assign id_valid_o       = id_valid_q;
    assign pc_fault_o       = fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed test-plan scenarios plus randomized traffic against a queue/array model.
module tb_instr_fetch_stage;

    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] branch_offset;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        pc_fault;

    instr_fetch_stage #(
        .IMEM_DEPTH(DEPTH),
        .RESET_PC  (32'h0000_0000),
        .NOP_WORD  (NOP)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_pc_i     (branch_pc),
        .branch_offset_i (branch_offset),
        .imem_we_i       (imem_we),
        .imem_waddr_i    (imem_waddr),
        .imem_wdata_i    (imem_wdata),
        .pc_o            (pc),
        .id_pc_o         (id_pc),
        .id_instruction_o(id_instruction),
        .id_valid_o      (id_valid),
        .pc_fault_o      (pc_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_idpc, m_idi;
    logic        m_idv, m_fault, m_halt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic bt,
                              input logic [31:0] bp, input logic [31:0] bo,
                              input logic we, input logic [5:0] wa, input logic [31:0] wd);
        bit          legal;
        logic [31:0] fw;
        legal = (m_pc % 4 == 0) && (m_pc < DEPTH * 4);
        fw    = legal ? m_mem[m_pc / 4] : 32'h0;
        if (!r) begin
            m_pc = 32'h0; m_idpc = 32'h0; m_idi = NOP; m_idv = 1'b0;
            m_fault = 1'b0; m_halt = 1'b0;
        end else if (!m_halt) begin
            if (bt) begin
                m_pc = bp + bo * 2;
                m_idpc = 32'h0; m_idi = NOP; m_idv = 1'b0;
            end else if (!st) begin
                if (legal) begin
                    m_idi = fw; m_idpc = m_pc; m_idv = 1'b1; m_pc = m_pc + 4;
                end else begin
                    m_fault = 1'b1; m_halt = 1'b1; m_idi = NOP; m_idv = 1'b0;
                end
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    task automatic compare_all();
        check("pc",             pc,                     m_pc);
        check("id_pc",          id_pc,                  m_idpc);
        check("id_instruction", id_instruction,         m_idi);
        check("id_valid",       {31'd0, id_valid},      {31'd0, m_idv});
        check("pc_fault",       {31'd0, pc_fault},      {31'd0, m_fault});
    endtask

    task automatic step(input logic r, input logic st, input logic bt,
                        input logic [31:0] bp, input logic [31:0] bo,
                        input logic we, input logic [5:0] wa, input logic [31:0] wd);
        rst_n = r; stall = st; branch_taken = bt; branch_pc = bp; branch_offset = bo;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        @(posedge clk);
        model_step(r, st, bt, bp, bo, we, wa, wd);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h00A00093; prog[1] = 32'h0010F113;
        prog[2] = 32'h00209463; prog[3] = 32'h00011183;
        m_pc = 32'h0; m_idpc = 32'h0; m_idi = NOP; m_idv = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        // Program load while held in reset
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'(i), (i < 4) ? prog[i] : $urandom);
        check("reset_id_instr", id_instruction, NOP);
        check("reset_pc", pc, 32'h0);

        // Sequential fetch of the program
        run(1);
        check("seq_c1_instr", id_instruction, 32'h00A00093);
        check("seq_c1_valid", {31'd0, id_valid}, 32'd1);
        run(3);
        check("seq_c4_instr", id_instruction, 32'h00011183);
        check("seq_c4_idpc", id_pc, 32'd12);

        // Stall at pc=8
        do_reset();
        run(2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0);
        check("stall_pc", pc, 32'd8);
        check("stall_instr", id_instruction, 32'h0010F113);
        check("stall_idpc", id_pc, 32'd4);
        run(1);
        check("resume_instr", id_instruction, 32'h00209463);

        // Branch overrides stall
        step(1'b1, 1'b1, 1'b1, 32'd8, 32'hFFFF_FFFC, 1'b0, 6'd0, 32'h0);
        check("br_pc", pc, 32'd0);
        check("br_flush_instr", id_instruction, NOP);
        check("br_flush_valid", {31'd0, id_valid}, 32'd0);
        run(1);
        check("br_target_instr", id_instruction, 32'h00A00093);

        // Misaligned branch target then halt
        step(1'b1, 1'b0, 1'b1, 32'd4, 32'd1, 1'b0, 6'd0, 32'h0);
        check("bad_br_pc", pc, 32'd6);
        run(1);
        check("halt_fault", {31'd0, pc_fault}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b1, 32'd0, 32'd0, 1'b0, 6'd0, 32'h0);
        check("halt_pc_holds", pc, 32'd6);

        // Reset with concurrent memory write in HALT
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6'd0, 32'h0000_0013);
        check("rst_halt_fault", {31'd0, pc_fault}, 32'd0);
        check("rst_halt_pc", pc, 32'd0);
        run(1);
        check("post_rst_instr", id_instruction, 32'h0000_0013);
        check("post_rst_idpc", id_pc, 32'd0);

        // Run off the end of memory
        do_reset();
        run(64);
        check("end_pc", pc, 32'h100);
        check("end_idpc", id_pc, 32'hFC);
        run(1);
        check("end_fault", {31'd0, pc_fault}, 32'd1);
        check("end_valid", {31'd0, id_valid}, 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, bt, we;
            logic [31:0] bp, bo;
            r  = ($urandom_range(0, 39) != 0);
            st = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 7) == 0);
            bp = $urandom_range(0, DEPTH - 1) * 4;
            bo = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 80)) - 32'd40;
            we = ($urandom_range(0, 9) == 0);
            step(r, st, bt, bp, bo, we, 6'($urandom_range(0, DEPTH - 1)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
